or1200mp_dbus_arbiter: RTL and testbench

//  Shares one data Wishbone bus between NUM_CORES or1200 data ports, each downstream of its CAS unit.

---
 rtl/or1200mp_dbus_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_or1200mp_dbus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/or1200mp_dbus_arbiter.sv
// ----------------------------------------------------------------------------
// or1200mp_dbus_arbiter
// Shares one data Wishbone bus among NUM_CORES or1200 data ports.
// - Round-robin arbitration. The owner keeps the bus for as long as it holds
//   cyc, so a CAS read-modify-write sequence stays atomic.
// - Every transfer that completes with ack is rebroadcast one cycle later as
//   a registered snoop beat for the cores' coherence inputs.
// - A per-beat watchdog ends a stalled transfer by giving the owner err.
// ----------------------------------------------------------------------------
module or1200mp_dbus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // master side
  input  logic [NUM_CORES-1:0]      m_cyc_i,
  input  logic [NUM_CORES-1:0]      m_stb_i,
  input  logic [NUM_CORES-1:0]      m_we_i,
  input  logic [4*NUM_CORES-1:0]    m_sel_i,
  input  logic [aw*NUM_CORES-1:0]   m_adr_i,
  input  logic [dw*NUM_CORES-1:0]   m_dat_i,
  output logic [dw-1:0]             m_dat_o,
  output logic [NUM_CORES-1:0]      m_ack_o,
  output logic [NUM_CORES-1:0]      m_err_o,
  output logic [NUM_CORES-1:0]      m_rty_o,
  // shared slave side
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [aw-1:0]             s_adr_o,
  output logic [dw-1:0]             s_dat_o,
  input  logic [dw-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  // ownership and snoop broadcast
  output logic [NUM_CORES-1:0]      grant_o,
  output logic                      snooped_ack_o,
  output logic                      snooped_we_o,
  output logic [aw-1:0]             snooped_adr_o,
  output logic [dw-1:0]             snooped_dat_o,
  output logic [3:0]                snooped_sel_o,
  output logic [2:0]                snooped_id_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C  = TIMEOUT[7:0];
  localparam logic       WD_EN_C    = (TIMEOUT != 0);
  localparam logic [2:0] LAST_RST_C = 3'(NUM_CORES - 1);
  localparam logic [NUM_CORES-1:0] ONE_C = {{(NUM_CORES-1){1'b0}}, 1'b1};

  // Round-robin search: first requester after 'last', wrapping modulo NUM_CORES.
  // Result is {hit, index}.
  function automatic logic [3:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                         input logic [2:0]           last);
    logic       hit;
    logic [2:0] idx;
    int         c;
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      c   = (int'(last) + i) % NUM_CORES;
      idx = (!hit && req[c]) ? c[2:0] : idx;
      hit = hit | req[c];
    end
    return {hit, idx};
  endfunction

  // state
  state_t               state_r, state_s;
  logic [2:0]           owner_r, owner_s;
  logic [NUM_CORES-1:0] grant_r, grant_s;
  logic [2:0]           last_r, last_s;
  logic [7:0]           wcnt_r, wcnt_s;

  logic                 snp_ack_r;
  logic                 snp_we_r;
  logic [aw-1:0]        snp_adr_r;
  logic [dw-1:0]        snp_dat_r;
  logic [3:0]           snp_sel_r;
  logic [2:0]           snp_id_r;

  // combinational helpers
  logic [NUM_CORES-1:0] req_s;
  logic [3:0]           pick_s;
  logic                 own_s;
  logic                 cyc_g_s, stb_g_s, we_g_s;
  logic [3:0]           sel_g_s;
  logic [aw-1:0]        adr_g_s;
  logic [dw-1:0]        dat_g_s;
  logic                 term_s;
  logic                 timeout_s;
  logic                 snp_hit_s;

  assign req_s  = m_cyc_i & m_stb_i;
  assign pick_s = rr_pick(req_s, last_r);
  assign term_s = s_ack_i | s_err_i | s_rty_i;

  // Select the owner's request signals using the one-hot grant as an AND-OR mask.
  always_comb begin
    cyc_g_s = 1'b0;
    stb_g_s = 1'b0;
    we_g_s  = 1'b0;
    sel_g_s = 4'd0;
    adr_g_s = {aw{1'b0}};
    dat_g_s = {dw{1'b0}};
    for (int k = 0; k < NUM_CORES; k++) begin
      cyc_g_s = cyc_g_s | (m_cyc_i[k] & grant_r[k]);
      stb_g_s = stb_g_s | (m_stb_i[k] & grant_r[k]);
      we_g_s  = we_g_s  | (m_we_i[k]  & grant_r[k]);
      sel_g_s = sel_g_s | (m_sel_i[4*k +: 4]   & {4{grant_r[k]}});
      adr_g_s = adr_g_s | (m_adr_i[aw*k +: aw] & {aw{grant_r[k]}});
      dat_g_s = dat_g_s | (m_dat_i[dw*k +: dw] & {dw{grant_r[k]}});
    end
  end

  // Drive the shared bus and route terminations back to the owner only.
  // Everything is gated off during the reset cycle so a late ack is dropped.
  always_comb begin
    own_s     = (state_r == ST_OWN) & ~rst_i;
    timeout_s = WD_EN_C & own_s & cyc_g_s & stb_g_s &
                (wcnt_r == TIMEOUT_C) & ~term_s;
    s_cyc_o   = own_s & cyc_g_s;
    s_stb_o   = own_s & cyc_g_s & stb_g_s & ~timeout_s;
    s_we_o    = own_s & we_g_s;
    s_sel_o   = sel_g_s & {4{own_s}};
    s_adr_o   = adr_g_s & {aw{own_s}};
    s_dat_o   = dat_g_s & {dw{own_s}};
    m_dat_o   = s_dat_i;
    m_ack_o   = grant_r & {NUM_CORES{s_ack_i & s_cyc_o}};
    m_err_o   = grant_r & {NUM_CORES{(s_err_i & s_cyc_o) | timeout_s}};
    m_rty_o   = grant_r & {NUM_CORES{s_rty_i & s_cyc_o}};
    snp_hit_s = s_cyc_o & s_stb_o & s_ack_i;
  end

  // Arbitration FSM next state: grant in IDLE, hold while owner keeps cyc.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    grant_s = grant_r;
    last_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[3]) begin
          state_s = ST_OWN;
          owner_s = pick_s[2:0];
          grant_s = ONE_C << pick_s[2:0];
        end else begin
          grant_s = {NUM_CORES{1'b0}};
        end
      end
      ST_OWN: begin
        if (!cyc_g_s) begin
          state_s = ST_IDLE;
          last_s  = owner_r;
          grant_s = {NUM_CORES{1'b0}};
        end else begin
          state_s = ST_OWN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = {NUM_CORES{1'b0}};
      end
    endcase
  end

  // Watchdog next value: count stalled strobe cycles, clear on any termination.
  always_comb begin
    if (WD_EN_C && own_s && cyc_g_s && stb_g_s && !term_s && !timeout_s) begin
      wcnt_s = wcnt_r + 8'd1;
    end else begin
      wcnt_s = 8'd0;
    end
  end

  // Arbiter state and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      owner_r <= 3'd0;
      grant_r <= {NUM_CORES{1'b0}};
      last_r  <= LAST_RST_C;
      wcnt_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      wcnt_r  <= wcnt_s;
    end
  end

  // Snoop beat: capture each acked transfer and pulse snooped_ack for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snp_ack_r <= 1'b0;
      snp_we_r  <= 1'b0;
      snp_adr_r <= {aw{1'b0}};
      snp_dat_r <= {dw{1'b0}};
      snp_sel_r <= 4'd0;
      snp_id_r  <= 3'd0;
    end else begin
      snp_ack_r <= snp_hit_s;
      if (snp_hit_s) begin
        snp_we_r  <= s_we_o;
        snp_adr_r <= s_adr_o;
        snp_dat_r <= s_we_o ? s_dat_o : s_dat_i;
        snp_sel_r <= s_sel_o;
        snp_id_r  <= owner_r;
      end else begin
        snp_we_r  <= snp_we_r;
        snp_adr_r <= snp_adr_r;
        snp_dat_r <= snp_dat_r;
        snp_sel_r <= snp_sel_r;
        snp_id_r  <= snp_id_r;
      end
    end
  end

  assign grant_o       = grant_r;
  assign snooped_ack_o = snp_ack_r;
  assign snooped_we_o  = snp_we_r;
  assign snooped_adr_o = snp_adr_r;
  assign snooped_dat_o = snp_dat_r;
  assign snooped_sel_o = snp_sel_r;
  assign snooped_id_o  = snp_id_r;

endmodule

// File: tb/tb_or1200mp_dbus_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for or1200mp_dbus_arbiter: cycle-by-cycle vector table with
// hand-computed expectations, plus short hand-written sequences.
// NUM_CORES=4, TIMEOUT=4.
// ----------------------------------------------------------------------------
module tb_or1200mp_dbus_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RDATA = 32'h1234_5678;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NC-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [4*NC-1:0]   m_sel_i;
  logic [AW*NC-1:0]  m_adr_i;
  logic [DW*NC-1:0]  m_dat_i;
  logic [DW-1:0]     m_dat_o;
  logic [NC-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [NC-1:0]     grant_o;
  logic              snooped_ack_o, snooped_we_o;
  logic [AW-1:0]     snooped_adr_o;
  logic [DW-1:0]     snooped_dat_o;
  logic [3:0]        snooped_sel_o;
  logic [2:0]        snooped_id_o;

  or1200mp_dbus_arbiter #(.NUM_CORES(NC), .dw(DW), .aw(AW), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .snooped_ack_o(snooped_ack_o), .snooped_we_o(snooped_we_o),
    .snooped_adr_o(snooped_adr_o), .snooped_dat_o(snooped_dat_o),
    .snooped_sel_o(snooped_sel_o), .snooped_id_o(snooped_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       rst;
    logic [3:0] cyc, stb, we;
    logic       ack, err;
    logic [3:0] e_grant;
    logic       e_cyc, e_stb;
    logic [3:0] e_ack, e_err;
    logic       e_snp, e_swe;
    logic [2:0] e_sid;
  } vec_t;

  localparam int NV = 50;
  vec_t vecs [NV];

  logic [31:0] adr_t [NC];
  logic [31:0] dat_t [NC];
  logic [3:0]  sel_t [NC];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic rst, logic [3:0] cyc, logic [3:0] stb, logic [3:0] we,
                              logic ack, logic err, logic [3:0] eg, logic ec, logic es,
                              logic [3:0] ea, logic [3:0] ee, logic esn, logic esw,
                              logic [2:0] eid);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.err = err;
    v.e_grant = eg; v.e_cyc = ec; v.e_stb = es; v.e_ack = ea; v.e_err = ee;
    v.e_snp = esn; v.e_swe = esw; v.e_sid = eid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gi;
    vec_t v;
    // per-core transfer attributes
    for (int k = 0; k < NC; k++) begin
      adr_t[k] = 32'(k + 1) * 32'h0000_0100;
      dat_t[k] = (k == 0) ? 32'hDEAD_BEEF : (32'hA5A5_0000 + 32'(k));
      sel_t[k] = (k == 0) ? 4'hF : (4'b0001 << k);
      m_sel_i[4*k +: 4]   = sel_t[k];
      m_adr_i[AW*k +: AW] = adr_t[k];
      m_dat_i[DW*k +: DW] = dat_t[k];
    end

    //            rst  cyc     stb     we      ack   err   grant   cy    st    ack     err     snp   swe   id
    // 1: single write by core0
    vecs[0]  = mk(1'b0,4'b0001,4'b0001,4'b0001,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[1]  = mk(1'b0,4'b0001,4'b0001,4'b0001,1'b1,1'b0, 4'b0001,1'b1,1'b1,4'b0001,4'b0000,1'b0,1'b0,3'd0);
    vecs[2]  = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0001,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b1,3'd0);
    vecs[3]  = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    // 2: reset, then cores 0,1,2 together; core0 re-requests during core1/2
    vecs[4]  = mk(1'b1,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[5]  = mk(1'b0,4'b0111,4'b0111,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[6]  = mk(1'b0,4'b0111,4'b0111,4'b0000,1'b1,1'b0, 4'b0001,1'b1,1'b1,4'b0001,4'b0000,1'b0,1'b0,3'd0);
    vecs[7]  = mk(1'b0,4'b0110,4'b0110,4'b0000,1'b0,1'b0, 4'b0001,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b0,3'd0);
    vecs[8]  = mk(1'b0,4'b0110,4'b0110,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[9]  = mk(1'b0,4'b0110,4'b0110,4'b0000,1'b1,1'b0, 4'b0010,1'b1,1'b1,4'b0010,4'b0000,1'b0,1'b0,3'd0);
    vecs[10] = mk(1'b0,4'b0101,4'b0101,4'b0000,1'b0,1'b0, 4'b0010,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b0,3'd1);
    vecs[11] = mk(1'b0,4'b0101,4'b0101,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[12] = mk(1'b0,4'b0101,4'b0101,4'b0000,1'b1,1'b0, 4'b0100,1'b1,1'b1,4'b0100,4'b0000,1'b0,1'b0,3'd0);
    vecs[13] = mk(1'b0,4'b0001,4'b0001,4'b0000,1'b0,1'b0, 4'b0100,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b0,3'd2);
    vecs[14] = mk(1'b0,4'b0001,4'b0001,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[15] = mk(1'b0,4'b0001,4'b0001,4'b0000,1'b1,1'b0, 4'b0001,1'b1,1'b1,4'b0001,4'b0000,1'b0,1'b0,3'd0);
    vecs[16] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0001,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b0,3'd0);
    vecs[17] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    // 3: core1 CAS read+write under one cyc, core2 waits
    vecs[18] = mk(1'b0,4'b0010,4'b0010,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[19] = mk(1'b0,4'b0110,4'b0110,4'b0000,1'b1,1'b0, 4'b0010,1'b1,1'b1,4'b0010,4'b0000,1'b0,1'b0,3'd0);
    vecs[20] = mk(1'b0,4'b0110,4'b0100,4'b0000,1'b0,1'b0, 4'b0010,1'b1,1'b0,4'b0000,4'b0000,1'b1,1'b0,3'd1);
    vecs[21] = mk(1'b0,4'b0110,4'b0110,4'b0010,1'b1,1'b0, 4'b0010,1'b1,1'b1,4'b0010,4'b0000,1'b0,1'b0,3'd0);
    vecs[22] = mk(1'b0,4'b0100,4'b0100,4'b0000,1'b0,1'b0, 4'b0010,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b1,3'd1);
    vecs[23] = mk(1'b0,4'b0100,4'b0100,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[24] = mk(1'b0,4'b0100,4'b0100,4'b0000,1'b1,1'b0, 4'b0100,1'b1,1'b1,4'b0100,4'b0000,1'b0,1'b0,3'd0);
    vecs[25] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0100,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b0,3'd2);
    vecs[26] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    // 4: core3 write, slave never answers -> err on 5th strobe cycle
    vecs[27] = mk(1'b0,4'b1000,4'b1000,4'b1000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    for (int i = 28; i < 32; i++)
      vecs[i] = mk(1'b0,4'b1000,4'b1000,4'b1000,1'b0,1'b0, 4'b1000,1'b1,1'b1,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[32] = mk(1'b0,4'b1000,4'b1000,4'b1000,1'b0,1'b0, 4'b1000,1'b1,1'b0,4'b0000,4'b1000,1'b0,1'b0,3'd0);
    vecs[33] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b1000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[34] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    // 5a: ack on the timeout cycle wins
    vecs[35] = mk(1'b0,4'b0001,4'b0001,4'b0001,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    for (int i = 36; i < 40; i++)
      vecs[i] = mk(1'b0,4'b0001,4'b0001,4'b0001,1'b0,1'b0, 4'b0001,1'b1,1'b1,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[40] = mk(1'b0,4'b0001,4'b0001,4'b0001,1'b1,1'b0, 4'b0001,1'b1,1'b1,4'b0001,4'b0000,1'b0,1'b0,3'd0);
    vecs[41] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0001,1'b0,1'b0,4'b0000,4'b0000,1'b1,1'b1,3'd0);
    // 5b: bus err on a core1 read, no snoop
    vecs[42] = mk(1'b0,4'b0010,4'b0010,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[43] = mk(1'b0,4'b0010,4'b0010,4'b0000,1'b0,1'b1, 4'b0010,1'b1,1'b1,4'b0000,4'b0010,1'b0,1'b0,3'd0);
    vecs[44] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0010,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[45] = mk(1'b0,4'b0000,4'b0000,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    // 6: reset during core2 beat with ack; core0 then wins over core2
    vecs[46] = mk(1'b0,4'b0100,4'b0100,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[47] = mk(1'b1,4'b0100,4'b0100,4'b0000,1'b1,1'b0, 4'b0100,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[48] = mk(1'b0,4'b0101,4'b0101,4'b0000,1'b0,1'b0, 4'b0000,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0);
    vecs[49] = mk(1'b0,4'b0101,4'b0101,4'b0000,1'b0,1'b0, 4'b0001,1'b1,1'b1,4'b0000,4'b0000,1'b0,1'b0,3'd0);

    // reset state
    rst_i = 1'b1;
    m_cyc_i = 4'b0000; m_stb_i = 4'b0000; m_we_i = 4'b0000;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    s_dat_i = RDATA;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_grant",   32'(grant_o), 32'h0);
    chk("rst_s_cyc",   32'(s_cyc_o), 32'h0);
    chk("rst_s_stb",   32'(s_stb_o), 32'h0);
    chk("rst_s_adr",   s_adr_o, 32'h0);
    chk("rst_m_ack",   32'(m_ack_o), 32'h0);
    chk("rst_snp_ack", 32'(snooped_ack_o), 32'h0);
    chk("rst_snp_adr", snooped_adr_o, 32'h0);
    chk("m_dat_pass",  m_dat_o, RDATA);

    // table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(posedge clk_i);
      #1;
      rst_i = v.rst; m_cyc_i = v.cyc; m_stb_i = v.stb; m_we_i = v.we;
      s_ack_i = v.ack; s_err_i = v.err;
      @(negedge clk_i);
      chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(v.e_grant));
      chk($sformatf("v%0d_s_cyc", i), 32'(s_cyc_o), 32'(v.e_cyc));
      chk($sformatf("v%0d_s_stb", i), 32'(s_stb_o), 32'(v.e_stb));
      chk($sformatf("v%0d_m_ack", i), 32'(m_ack_o), 32'(v.e_ack));
      chk($sformatf("v%0d_m_err", i), 32'(m_err_o), 32'(v.e_err));
      chk($sformatf("v%0d_snp_ack", i), 32'(snooped_ack_o), 32'(v.e_snp));
      if (v.e_cyc) begin
        gi = 0;
        for (int k = 0; k < NC; k++) if (v.e_grant[k]) gi = k;
        chk($sformatf("v%0d_s_adr", i), s_adr_o, adr_t[gi]);
        chk($sformatf("v%0d_s_dat", i), s_dat_o, dat_t[gi]);
        chk($sformatf("v%0d_s_sel", i), 32'(s_sel_o), 32'(sel_t[gi]));
        chk($sformatf("v%0d_s_we", i),  32'(s_we_o), 32'(v.we[gi]));
      end
      if (v.e_snp) begin
        chk($sformatf("v%0d_snp_id", i),  32'(snooped_id_o), 32'(v.e_sid));
        chk($sformatf("v%0d_snp_we", i),  32'(snooped_we_o), 32'(v.e_swe));
        chk($sformatf("v%0d_snp_adr", i), snooped_adr_o, adr_t[v.e_sid]);
        chk($sformatf("v%0d_snp_sel", i), 32'(snooped_sel_o), 32'(sel_t[v.e_sid]));
        chk($sformatf("v%0d_snp_dat", i), snooped_dat_o,
            v.e_swe ? dat_t[v.e_sid] : RDATA);
      end
    end

    // retry to current owner (core0): routed to owner only, no snoop beat
    @(posedge clk_i);
    #1;
    s_rty_i = 1'b1;
    @(negedge clk_i);
    chk("rty_m_rty", 32'(m_rty_o), 32'h1);
    chk("rty_m_ack", 32'(m_ack_o), 32'h0);
    @(posedge clk_i);
    #1;
    s_rty_i = 1'b0; m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    @(negedge clk_i);
    chk("rty_no_snoop", 32'(snooped_ack_o), 32'h0);
    chk("rty_m_rty_clr", 32'(m_rty_o), 32'h0);
    chk("rty_s_cyc", 32'(s_cyc_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
